rob_queue: RTL and testbench

Parametrised circular reorder buffer for the out-of-order core, successor to the fixed 8-entry ROB. Sits between rename/dispatch and the commit stage: allocates up to DISPATCH_WIDTH entries per cycle in program order, accepts out-of-order completion from WB_PORTS writeback ports, and retires up to COMMIT_WIDTH consecutive completed entries per cycle from the head. Commit output carries the old physical register so the free list can reclaim it.

---
 rtl/rob_pkg.sv | 32 +++
 rtl/rob_commit_sel.sv | 24 ++
 rtl/rob_queue.sv | 148 ++++++++++++++
 tb/tb_rob_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// Entry layout, pointer types and age helper.
package rob_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int DISPATCH_WIDTH = 4;
  localparam int COMMIT_WIDTH   = 4;
  localparam int WB_PORTS       = 4;
  localparam int AREG_W         = 5;
  localparam int PREG_W         = 6;
  localparam int IDX_W          = $clog2(ROB_DEPTH);
  localparam int CNT_W          = $clog2(ROB_DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dst;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
  } rob_entry_t;

  // Distance of idx from head in program order (0 = oldest).
  function automatic idx_t rob_age(idx_t idx, idx_t head);
    return idx - head;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Prefix scan of valid&done entries starting at head.
// Yields the retiring lane mask and its population.
module rob_commit_sel
  import rob_pkg::*;
(
  input  logic [ROB_DEPTH-1:0]    vd,
  input  idx_t                    head_idx,
  output logic [COMMIT_WIDTH-1:0] mask,
  output cnt_t                    cnt
);

  always_comb begin
    logic run;
    run  = 1'b1;
    mask = '0;
    cnt  = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run     = run & vd[head_idx + idx_t'(k)];
      mask[k] = run;
      cnt     = cnt + cnt_t'(run);
    end
  end

endmodule

// File: rtl/rob_queue.sv
// Circular reorder buffer: in-order alloc/retire, OoO completion.
// ROB_PARTIAL_FLUSH_EN selects partial flush; default flushes all.
module rob_queue
  import rob_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DISPATCH_WIDTH-1:0]               disp_valid,
  input  logic [DISPATCH_WIDTH-1:0]               disp_has_dst,
  input  logic [DISPATCH_WIDTH-1:0][AREG_W-1:0]   disp_areg,
  input  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0]   disp_preg,
  input  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0]   disp_old_preg,
  output logic                                    disp_ready,
  output logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]    disp_rob_idx,
  input  logic [WB_PORTS-1:0]                     wb_valid,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]          wb_rob_idx,
  input  logic                                    flush_valid,
  input  logic [IDX_W-1:0]                        flush_rob_idx,
  output logic [COMMIT_WIDTH-1:0]                 commit_valid,
  output logic [COMMIT_WIDTH-1:0]                 commit_has_dst,
  output logic [COMMIT_WIDTH-1:0][AREG_W-1:0]     commit_areg,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]     commit_preg,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]     commit_old_preg,
  output logic [CNT_W-1:0]                        rob_count,
  output logic                                    rob_empty,
  output logic                                    rob_full
);

  rob_entry_t ent [ROB_DEPTH];
  ptr_t head, tail;
  cnt_t count;
  idx_t head_idx, tail_idx;

  logic [ROB_DEPTH-1:0]    vd;
  logic [COMMIT_WIDTH-1:0] sel_mask, cmt_mask;
  cnt_t sel_cnt, n_cmt, n_disp;
  logic do_disp, do_flush;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  always_comb
    for (int i = 0; i < ROB_DEPTH; i++)
      vd[i] = ent[i].valid & ent[i].done;

  rob_commit_sel u_sel (
    .vd       (vd),
    .head_idx (head_idx),
    .mask     (sel_mask),
    .cnt      (sel_cnt)
  );

`ifdef ROB_PARTIAL_FLUSH_EN
  idx_t flush_age;

  assign flush_age = rob_age(flush_rob_idx, head_idx);
  assign do_flush  = flush_valid & ent[flush_rob_idx].valid;

  // Only entries at or older than the flush point may retire.
  always_comb begin
    cmt_mask = sel_mask;
    n_cmt    = sel_cnt;
    if (do_flush && sel_cnt > cnt_t'(flush_age)) begin
      n_cmt = cnt_t'(flush_age) + cnt_t'(1);
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (idx_t'(k) > flush_age) cmt_mask[k] = 1'b0;
    end
  end
`else
  logic unused_flush_idx;

  assign unused_flush_idx = ^flush_rob_idx;
  assign do_flush = flush_valid;
  assign cmt_mask = flush_valid ? '0 : sel_mask;
  assign n_cmt    = flush_valid ? '0 : sel_cnt;
`endif

  assign disp_ready = count <= cnt_t'(ROB_DEPTH - DISPATCH_WIDTH);
  assign do_disp    = disp_ready & disp_valid[0] & ~do_flush;

  always_comb begin
    n_disp = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      n_disp = n_disp + cnt_t'(disp_valid[i]);
    if (!do_disp) n_disp = '0;
  end

  always_comb
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      disp_rob_idx[i] = tail_idx + idx_t'(i);

  always_comb
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_has_dst[k]  = ent[head_idx + idx_t'(k)].has_dst;
      commit_areg[k]     = ent[head_idx + idx_t'(k)].areg;
      commit_preg[k]     = ent[head_idx + idx_t'(k)].preg;
      commit_old_preg[k] = ent[head_idx + idx_t'(k)].old_preg;
    end

  assign commit_valid = cmt_mask;
  assign rob_count    = count;
  assign rob_empty    = count == '0;
  assign rob_full     = count == cnt_t'(ROB_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && ent[wb_rob_idx[p]].valid)
          ent[wb_rob_idx[p]].done <= 1'b1;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (cmt_mask[k]) ent[head_idx + idx_t'(k)] <= '0;
      head <= head + ptr_t'(n_cmt);
      if (do_flush) begin
`ifdef ROB_PARTIAL_FLUSH_EN
        for (int i = 0; i < ROB_DEPTH; i++)
          if (rob_age(idx_t'(i), head_idx) > flush_age)
            ent[i] <= '0;
        tail  <= head + ptr_t'(flush_age) + ptr_t'(1);
        count <= cnt_t'(flush_age) + cnt_t'(1) - n_cmt;
`else
        for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
        tail  <= head;
        count <= '0;
`endif
      end else begin
        if (do_disp)
          for (int i = 0; i < DISPATCH_WIDTH; i++)
            if (disp_valid[i])
              ent[tail_idx + idx_t'(i)] <= '{
                valid:    1'b1,
                done:     1'b0,
                has_dst:  disp_has_dst[i],
                areg:     disp_areg[i],
                preg:     disp_preg[i],
                old_preg: disp_old_preg[i]
              };
        tail  <= tail + ptr_t'(n_disp);
        count <= count + n_disp - n_cmt;
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Randomized bench for rob_queue against a queue-based model.
// Follows ROB_PARTIAL_FLUSH_EN the same way as the design.
module tb_rob_queue;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [DISPATCH_WIDTH-1:0]             disp_valid, disp_has_dst;
  logic [DISPATCH_WIDTH-1:0][AREG_W-1:0] disp_areg;
  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0] disp_preg, disp_old_preg;
  logic                                  disp_ready;
  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]  disp_rob_idx;
  logic [WB_PORTS-1:0]                   wb_valid;
  logic [WB_PORTS-1:0][IDX_W-1:0]        wb_rob_idx;
  logic                                  flush_valid;
  logic [IDX_W-1:0]                      flush_rob_idx;
  logic [COMMIT_WIDTH-1:0]               commit_valid, commit_has_dst;
  logic [COMMIT_WIDTH-1:0][AREG_W-1:0]   commit_areg;
  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]   commit_preg, commit_old_preg;
  logic [CNT_W-1:0]                      rob_count;
  logic                                  rob_empty, rob_full;

  rob_queue dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_has_dst(disp_has_dst),
    .disp_areg(disp_areg), .disp_preg(disp_preg),
    .disp_old_preg(disp_old_preg), .disp_ready(disp_ready),
    .disp_rob_idx(disp_rob_idx),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx),
    .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
    .commit_valid(commit_valid), .commit_has_dst(commit_has_dst),
    .commit_areg(commit_areg), .commit_preg(commit_preg),
    .commit_old_preg(commit_old_preg),
    .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              has_dst;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old;
    logic              done;
  } m_ent_t;

  m_ent_t q[$];
  int m_head;
  int n_checks, n_errors;
  bit chk_en;

`ifdef ROB_PARTIAL_FLUSH_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    disp_valid    = '0;
    disp_has_dst  = '0;
    disp_areg     = '0;
    disp_preg     = '0;
    disp_old_preg = '0;
    wb_valid      = '0;
    wb_rob_idx    = '0;
    flush_valid   = 1'b0;
    flush_rob_idx = '0;
  endtask

  task automatic set_disp(input int n, input int base);
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      disp_valid[i]    = (i < n);
      disp_has_dst[i]  = 1'b1;
      disp_areg[i]     = AREG_W'(base + i);
      disp_preg[i]     = PREG_W'(32 + base + i);
      disp_old_preg[i] = PREG_W'(base + i);
    end
  endtask

  task automatic drive_rand();
    int n;
    idle();
    n = $urandom_range(0, DISPATCH_WIDTH);
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      disp_valid[i]    = (i < n);
      disp_has_dst[i]  = 1'($urandom);
      disp_areg[i]     = AREG_W'($urandom);
      disp_preg[i]     = PREG_W'($urandom);
      disp_old_preg[i] = PREG_W'($urandom);
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_valid[p] = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 7) != 0)
        wb_rob_idx[p] = IDX_W'(m_head + int'($urandom_range(0, q.size() - 1)));
      else
        wb_rob_idx[p] = IDX_W'($urandom);
    end
    flush_valid   = ($urandom_range(0, 40) == 0);
    flush_rob_idx = IDX_W'($urandom);
    rst           = ($urandom_range(0, 800) == 0);
  endtask

  // Check outputs against the model, then advance model and clock.
  task automatic step();
    int sz, nc, fage, j;
    bit fl;
    m_ent_t e;
    logic [COMMIT_WIDTH-1:0] ecv;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] eidx;
    #1;
    sz = q.size();
    nc = 0;
    while (nc < COMMIT_WIDTH && nc < sz && q[nc].done) nc++;
    fage = (int'(flush_rob_idx) - m_head) & (ROB_DEPTH - 1);
    if (PARTIAL) begin
      fl = flush_valid && fage < sz;
      if (fl && nc > fage + 1) nc = fage + 1;
    end else begin
      fl = flush_valid;
      if (fl) nc = 0;
    end
    if (chk_en) begin
      ecv = '0;
      for (int k = 0; k < nc; k++) ecv[k] = 1'b1;
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        eidx[i] = IDX_W'((m_head + sz + i) & (ROB_DEPTH - 1));
      chk("count", 32'(rob_count), 32'(sz));
      chk("empty", 32'(rob_empty), 32'(sz == 0));
      chk("full", 32'(rob_full), 32'(sz == ROB_DEPTH));
      chk("ready", 32'(disp_ready), 32'(sz <= ROB_DEPTH - DISPATCH_WIDTH));
      chk("rob_idx", 32'(disp_rob_idx), 32'(eidx));
      chk("cvalid", 32'(commit_valid), 32'(ecv));
      for (int k = 0; k < nc; k++)
        chk("cfields",
            32'({commit_has_dst[k], commit_areg[k],
                 commit_preg[k], commit_old_preg[k]}),
            32'({q[k].has_dst, q[k].areg, q[k].preg, q[k].old}));
    end
    if (rst) begin
      q.delete();
      m_head = 0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p]) begin
          j = (int'(wb_rob_idx[p]) - m_head) & (ROB_DEPTH - 1);
          if (j < sz) q[j].done = 1'b1;
        end
      if (fl) begin
        if (PARTIAL)
          while (q.size() > fage + 1) void'(q.pop_back());
        else
          q.delete();
      end
      for (int k = 0; k < nc; k++) void'(q.pop_front());
      m_head = (m_head + nc) & (ROB_DEPTH - 1);
      if (!fl && sz <= ROB_DEPTH - DISPATCH_WIDTH && disp_valid[0])
        for (int i = 0; i < DISPATCH_WIDTH; i++)
          if (disp_valid[i]) begin
            e.has_dst = disp_has_dst[i];
            e.areg    = disp_areg[i];
            e.preg    = disp_preg[i];
            e.old     = disp_old_preg[i];
            e.done    = 1'b0;
            q.push_back(e);
          end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] ridx;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    m_head   = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    #1;
    for (int i = 0; i < DISPATCH_WIDTH; i++) ridx[i] = IDX_W'(i);
    chk("rst_ready", 32'(disp_ready), 32'd1);
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_cvalid", 32'(commit_valid), 32'd0);
    chk("rst_idx", 32'(disp_rob_idx), 32'(ridx));

    set_disp(4, 1);
    step();
    idle();
    #1;
    chk("disp_cnt", 32'(rob_count), 32'd4);
    step();
    wb_valid[0] = 1'b1; wb_rob_idx[0] = IDX_W'(2);
    wb_valid[1] = 1'b1; wb_rob_idx[1] = IDX_W'(3);
    step();
    idle();
    wb_valid[0] = 1'b1; wb_rob_idx[0] = IDX_W'(0);
    step();
    idle();
    wb_valid[0] = 1'b1; wb_rob_idx[0] = IDX_W'(1);
    #1;
    chk("cv_0001", 32'(commit_valid), 32'h1);
    step();
    idle();
    #1;
    chk("cv_0111", 32'(commit_valid), 32'h7);
    chk("c_areg0", 32'(commit_areg[0]), 32'd2);
    step();

    for (int c = 0; c < 4; c++) begin
      set_disp(4, 8 + 4 * c);
      step();
    end
    idle();
    #1;
    chk("fill_full", 32'(rob_full), 32'd1);
    chk("fill_ready", 32'(disp_ready), 32'd0);
    set_disp(4, 1);
    step();
    idle();
    #1;
    chk("drop_cnt", 32'(rob_count), 32'd16);
    chk("drop_tail", 32'(disp_rob_idx[0]), 32'd4);
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p]   = 1'b1;
        wb_rob_idx[p] = IDX_W'(4 + 4 * c + p);
      end
      step();
    end
    idle();
    repeat (8) step();
    #1;
    chk("drained", 32'(rob_empty), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      drive_rand();
      step();
    end

    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_disp(4, 1);
    step();
    set_disp(4, 5);
    step();
    idle();
    wb_valid[0] = 1'b1; wb_rob_idx[0] = IDX_W'(0);
    step();
    idle();
    flush_valid   = 1'b1;
    flush_rob_idx = IDX_W'(3);
    wb_valid[0]   = 1'b1;
    wb_rob_idx[0] = IDX_W'(5);
    #1;
    chk("flush_cv", 32'(commit_valid), PARTIAL ? 32'h1 : 32'h0);
    step();
    idle();
    #1;
    chk("flush_cnt", 32'(rob_count), PARTIAL ? 32'd3 : 32'd0);
    chk("flush_tail", 32'(disp_rob_idx[0]), PARTIAL ? 32'd4 : 32'd0);
    chk("flush_empty", 32'(rob_empty), PARTIAL ? 32'd0 : 32'd1);
    step();
    set_disp(4, 20);
    for (int p = 0; p < 3; p++) begin
      wb_valid[p]   = 1'b1;
      wb_rob_idx[p] = IDX_W'(p + 1);
    end
    step();
    idle();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
